interp_feeder: RTL and testbench
================================

// Module: interp_feeder
// PURPOSE
// Upstream feeder for the 2D interpolator core (rtl_top).
// - Holds the 8-entry knot/weight table as a shadow bank (host-written) and an active bank (drives core).
// - Buffers incoming x samples in a small FIFO (valid/ready).
// - Issues one sample per cycle as o_en/o_x/o_weight0..7, which connect directly to the core's i_en/i_x/i_weight0..7.
// PARAMETERS
// X_W    8   width of sample x
// W_W    12  width of each weight entry
// DEPTH  4   sample FIFO depth (power of 2, >=2)
// PORTS
// clk         in   1           core clock, all state on rising edge
// rst         in   1           asynchronous, active-high reset
// wr_en       in   1           write shadow weight entry
// wr_addr     in   3           shadow entry index 0..7
// wr_data     in   W_W         shadow entry value
// commit      in   1           request copy shadow->active bank
// s_valid     in   1           sample valid
// s_ready     out  1           sample accepted when s_valid&&s_ready at edge
// s_x         in   X_W         sample value
// i_hold      in   1           downstream stall; no pop while high
// o_en        out  1           sample strobe to core
// o_x         out  X_W         sample to core
// o_weight0..7 out W_W each    active bank entries 0..7
// o_level     out  clog2(DEPTH)+1  FIFO occupancy
// o_sample_cnt out 16          emitted samples, wraps 0xFFFF->0
// BEHAVIOUR
// - Reset (async): state=S_EMPTY; FIFO empty; shadow/active banks, o_x, o_sample_cnt = 0; o_en=0; s_ready=0; o_level=0.
// - FSM (3 states):
//   S_EMPTY: no bank committed yet; s_ready=0; commit -> S_SWAP.
//   S_RUN:   normal; commit -> S_SWAP.
//   S_SWAP:  one cycle, no pop; on exit active<=shadow; commit seen here -> stay S_SWAP one more cycle, else -> S_RUN.
// - Shadow write:
//   - shadow[wr_addr]<=wr_data every wr_en edge, in any state.
//   - Write in the last S_SWAP cycle is forwarded: active receives wr_data for that entry.
// - s_ready = (state!=S_EMPTY) && (o_level<DEPTH). Full FIFO: s_ready=0 even if a pop occurs that cycle (no pass-through).
// - pop = (state==S_RUN) && !i_hold && (o_level!=0).
//   - On pop edge: o_en<=1, o_x<=FIFO head, o_sample_cnt++.
//   - Else: o_en<=0, o_x holds its value.
// - Push and pop in the same cycle: o_level unchanged, data order preserved.
// - Latency:
//   - Sample accepted at edge E, FIFO empty, no hold: o_en=1 in the cycle after edge E+1.
//   - Throughput 1/cycle.
// - Weight alignment:
//   - o_weightN are the active registers.
//   - A sample popped on the edge entering S_SWAP is presented with the OLD bank.
//   - The first sample after S_SWAP uses the NEW bank.
//   - o_en is never 1 in the cycle where the bank changes.
// - i_hold: freezes pops only; pushes continue until full.
// - Reset mid-stream: buffered samples are discarded; S_EMPTY requires a new commit before accepting samples.
// STRUCTURE
// - interp_pkg: NUM_KNOTS=8; typedef logic [X_W-1:0] x_t; typedef logic [W_W-1:0] weight_t; enum state_t {S_EMPTY,S_RUN,S_SWAP}.
// - Sub-module interp_sync_fifo:
//   - Parameterised by width and DEPTH.
//   - push/pop/level; wrap-around pointers with an extra MSB.
//   - Async active-high reset.
// - Top holds the FSM, the two banks, output registers and the counter.
// TESTING
// 1. Sample before commit: s_valid=1, s_x=24, no commit -> s_ready=0, o_en=0, o_level=0.
// 2. Write weights 104,235,293,439,595,662,691,694 to addr 0..7, commit, then s_x=24 -> o_weight0..7 equal those values; o_en=1 with o_x=24 two edges after accept; o_sample_cnt=1.
// 3. i_hold=1, push 5 samples 1..5 -> first 4 accepted, s_ready=0, o_level=4; release hold -> o_x=1,2,3,4 on consecutive cycles, then o_level=0.
// 4. Streaming x=10,11,12, with wr addr0=500 and commit asserted alongside x=11's pop -> x=11 presented with o_weight0=104; one cycle o_en=0; x=12 presented with o_weight0=500.
// 5. Assert rst for 1 cycle with o_level=3 -> o_level=0, o_en=0, all weights 0, state S_EMPTY (s_ready=0).
// 6. 65536 pops -> o_sample_cnt wraps to 0.

Source files
------------

// File: rtl/interp_feeder_pkg.sv
// Shared types and constants for the interpolator feeder slice.
package interp_pkg;

  localparam int NUM_KNOTS = 8;
  localparam int X_W_DEF   = 8;
  localparam int W_W_DEF   = 12;

  typedef logic [X_W_DEF-1:0] x_t;
  typedef logic [W_W_DEF-1:0] weight_t;

  // Explicit encoding so the state values match the legacy numbering.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_RUN   = 2'd1,
    S_SWAP  = 2'd2
  } state_t;

endpackage

// File: rtl/interp_feeder_fifo.sv
// Small synchronous sample FIFO with wrap-around pointers (extra MSB
// distinguishes full from empty). Caller must not push when full or
// pop when empty.
module interp_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  // Next-pointer computation.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
  end

  // Pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

  assign dout  = mem_q[rd_ptr_q[AW-1:0]];
  assign level = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/interp_feeder.sv
// Upstream feeder for the 2D interpolator core: shadow/active weight
// banks, sample FIFO, and one-sample-per-cycle issue to the core.
module interp_feeder
  import interp_pkg::*;
#(
  parameter int X_W   = 8,
  parameter int W_W   = 12,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [2:0]             wr_addr,
  input  logic [W_W-1:0]         wr_data,
  input  logic                   commit,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [X_W-1:0]         s_x,
  input  logic                   i_hold,
  output logic                   o_en,
  output logic [X_W-1:0]         o_x,
  output logic [W_W-1:0]         o_weight0,
  output logic [W_W-1:0]         o_weight1,
  output logic [W_W-1:0]         o_weight2,
  output logic [W_W-1:0]         o_weight3,
  output logic [W_W-1:0]         o_weight4,
  output logic [W_W-1:0]         o_weight5,
  output logic [W_W-1:0]         o_weight6,
  output logic [W_W-1:0]         o_weight7,
  output logic [$clog2(DEPTH):0] o_level,
  output logic [15:0]            o_sample_cnt
);

  localparam int LW = $clog2(DEPTH) + 1;

  state_t         state_q, state_d;
  logic [W_W-1:0] shadow_q [NUM_KNOTS];
  logic [W_W-1:0] shadow_d [NUM_KNOTS];
  logic [W_W-1:0] active_q [NUM_KNOTS];
  logic [W_W-1:0] active_d [NUM_KNOTS];
  logic           o_en_q, o_en_d;
  logic [X_W-1:0] o_x_q, o_x_d;
  logic [15:0]    cnt_q, cnt_d;

  logic [LW-1:0]  level;
  logic [X_W-1:0] head;
  logic           push, pop;

  // Handshake: full FIFO never accepts, even when popping that cycle.
  assign s_ready = (state_q != S_EMPTY) && (level < LW'(DEPTH));
  assign push    = s_valid && s_ready;
  assign pop     = (state_q == S_RUN) && !i_hold && (level != '0);

  interp_sync_fifo #(
    .WIDTH (X_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (s_x),
    .dout  (head),
    .level (level)
  );

  // Next-state, bank update and output-register logic.
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    active_d = active_q;
    o_en_d   = pop;
    o_x_d    = pop ? head : o_x_q;
    cnt_d    = cnt_q + 16'(pop);

    unique case (state_q)
      S_EMPTY: if (commit) state_d = S_SWAP;
      S_RUN:   if (commit) state_d = S_SWAP;
      S_SWAP:  state_d = commit ? S_SWAP : S_RUN;
      default: state_d = S_EMPTY;
    endcase

    if (wr_en) shadow_d[wr_addr] = wr_data;

    // Copy from shadow_d so a write landing on the exit edge is forwarded.
    if ((state_q == S_SWAP) && !commit) active_d = shadow_d;
  end

  // State, banks, output registers and sample counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_EMPTY;
      shadow_q <= '{default: '0};
      active_q <= '{default: '0};
      o_en_q   <= 1'b0;
      o_x_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      o_en_q   <= o_en_d;
      o_x_q    <= o_x_d;
      cnt_q    <= cnt_d;
    end
  end

  assign o_en         = o_en_q;
  assign o_x          = o_x_q;
  assign o_level      = level;
  assign o_sample_cnt = cnt_q;
  assign o_weight0    = active_q[0];
  assign o_weight1    = active_q[1];
  assign o_weight2    = active_q[2];
  assign o_weight3    = active_q[3];
  assign o_weight4    = active_q[4];
  assign o_weight5    = active_q[5];
  assign o_weight6    = active_q[6];
  assign o_weight7    = active_q[7];

endmodule

// File: tb/tb_interp_feeder.sv
// Self-checking bench for interp_feeder: scoreboard of (x, weight0)
// pairs pushed on accept and compared on each o_en strobe.
module tb_interp_feeder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_addr = '0;
  logic [11:0] wr_data = '0;
  logic        commit = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [7:0]  s_x = '0;
  logic        i_hold = 1'b0;
  logic        o_en;
  logic [7:0]  o_x;
  logic [11:0] wt [8];
  logic [2:0]  o_level;
  logic [15:0] o_sample_cnt;

  typedef struct {
    logic [7:0]  x;
    logic [11:0] w0;
  } sb_t;

  sb_t         sb [$];
  bit          sb_en = 1'b1;
  int          checks = 0;
  int          failures = 0;
  logic [15:0] exp_cnt = '0;
  int          pop_seen = 0;

  logic [11:0] wtab [8] = '{12'd104, 12'd235, 12'd293, 12'd439,
                            12'd595, 12'd662, 12'd691, 12'd694};

  interp_feeder #(.X_W(8), .W_W(12), .DEPTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .commit       (commit),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_x          (s_x),
    .i_hold       (i_hold),
    .o_en         (o_en),
    .o_x          (o_x),
    .o_weight0    (wt[0]),
    .o_weight1    (wt[1]),
    .o_weight2    (wt[2]),
    .o_weight3    (wt[3]),
    .o_weight4    (wt[4]),
    .o_weight5    (wt[5]),
    .o_weight6    (wt[6]),
    .o_weight7    (wt[7]),
    .o_level      (o_level),
    .o_sample_cnt (o_sample_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_w(input logic [2:0] a, input logic [11:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic do_commit();
    commit = 1'b1;
    tick();
    commit = 1'b0;
  endtask

  // Offer one sample; records the expectation at the accepting edge.
  task automatic send(input logic [7:0] x, input logic [11:0] w0);
    bit done = 1'b0;
    s_valid = 1'b1;
    s_x = x;
    for (int n = 0; n < 20 && !done; n++) begin
      if (s_ready) begin
        if (sb_en) sb.push_back('{x: x, w0: w0});
        done = 1'b1;
      end
      tick();
    end
    s_valid = 1'b0;
    if (!done) chk("send_timeout", 0, 1);
  endtask

  // Output monitor: compares each strobe against the scoreboard head.
  always @(negedge clk) begin
    sb_t e;
    if (rst) begin
      sb.delete();
      exp_cnt  = '0;
      pop_seen = 0;
    end else if (o_en) begin
      pop_seen++;
      exp_cnt++;
      if (sb_en) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("sb_x", 32'(o_x), 32'(e.x));
          chk("sb_w0", 32'(wt[0]), 32'(e.w0));
          chk("sb_cnt", 32'(o_sample_cnt), 32'(exp_cnt));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_level", 32'(o_level), 0);
    chk("rst_en", 32'(o_en), 0);
    chk("rst_x", 32'(o_x), 0);
    chk("rst_cnt", 32'(o_sample_cnt), 0);
    chk("rst_w0", 32'(wt[0]), 0);
    rst = 1'b0;

    // 1. Sample before any commit is refused
    s_valid = 1'b1; s_x = 8'd24;
    tick(); tick(); tick();
    chk("t1_ready", 32'(s_ready), 0);
    chk("t1_en", 32'(o_en), 0);
    chk("t1_level", 32'(o_level), 0);
    s_valid = 1'b0;

    // 2. Load bank, commit, first sample with latency
    for (int i = 0; i < 8; i++) wr_w(3'(i), wtab[i]);
    chk("t2_shadow_only", 32'(wt[3]), 0);
    do_commit();
    send(8'd24, 12'd104);
    chk("t2_lat_en0", 32'(o_en), 0);
    tick();
    chk("t2_en", 32'(o_en), 1);
    chk("t2_x", 32'(o_x), 24);
    for (int i = 0; i < 8; i++) chk($sformatf("t2_w%0d", i), 32'(wt[i]), 32'(wtab[i]));
    chk("t2_cnt", 32'(o_sample_cnt), 1);

    // 3. Hold fills the FIFO; release drains in order at 1/cycle
    tick();
    i_hold = 1'b1;
    for (int i = 1; i <= 4; i++) send(8'(i), 12'd104);
    s_valid = 1'b1; s_x = 8'd5;
    tick();
    chk("t3_full_ready", 32'(s_ready), 0);
    chk("t3_level", 32'(o_level), 4);
    i_hold = 1'b0;
    chk("t3_no_passthru", 32'(s_ready), 0);
    s_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("t3_en", 32'(o_en), 1);
      chk("t3_x", 32'(o_x), 32'(i));
    end
    chk("t3_empty", 32'(o_level), 0);
    tick();
    chk("t3_idle", 32'(o_en), 0);

    // 4. Bank swap alongside a stream, with a forwarded write
    wr_w(3'd0, 12'd500);
    chk("t4_active_kept", 32'(wt[0]), 104);
    send(8'd10, 12'd104);
    send(8'd11, 12'd104);
    chk("t4_x10", 32'(o_x), 10);
    commit = 1'b1;
    send(8'd12, 12'd500);
    commit = 1'b0;
    chk("t4_en11", 32'(o_en), 1);
    chk("t4_x11", 32'(o_x), 11);
    chk("t4_old_w0", 32'(wt[0]), 104);
    wr_en = 1'b1; wr_addr = 3'd1; wr_data = 12'd777;
    tick();
    wr_en = 1'b0;
    chk("t4_gap_en", 32'(o_en), 0);
    chk("t4_new_w0", 32'(wt[0]), 500);
    chk("t4_fwd_w1", 32'(wt[1]), 777);
    tick();
    chk("t4_en12", 32'(o_en), 1);
    chk("t4_x12", 32'(o_x), 12);
    tick();
    chk("sb_drained", 32'(sb.size()), 0);

    // 5. Reset mid-stream discards buffered samples
    i_hold = 1'b1;
    send(8'd30, 12'd500);
    send(8'd31, 12'd500);
    send(8'd32, 12'd500);
    chk("t5_level3", 32'(o_level), 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_level", 32'(o_level), 0);
    chk("t5_en", 32'(o_en), 0);
    chk("t5_ready", 32'(s_ready), 0);
    chk("t5_cnt", 32'(o_sample_cnt), 0);
    for (int i = 0; i < 8; i++) chk($sformatf("t5_w%0d", i), 32'(wt[i]), 0);
    i_hold = 1'b0;
    s_valid = 1'b1; s_x = 8'd40;
    tick(); tick(); tick();
    chk("t5_empty_ready", 32'(s_ready), 0);
    chk("t5_empty_en", 32'(o_en), 0);
    s_valid = 1'b0;

    // 6. Counter wrap after 65536 pops
    do_commit();
    sb_en = 1'b0;
    for (int i = 0; i < 65536; i++) send(8'(i), 12'd0);
    tick(); tick(); tick(); tick();
    chk("t6_pops", 32'(pop_seen), 65536);
    chk("t6_wrap", 32'(o_sample_cnt), 0);
    chk("t6_level", 32'(o_level), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
